// File: rtl/riscv_hazard_scoreboard.sv
// Hazard unit: EX operand forwarding, ID stall/bubble generation and a scoreboard of
// destination registers owned by outstanding long-latency (mul/div) operations.
module riscv_hazard_scoreboard #(
    parameter int RF_ADDR_WIDTH   = 5,
    parameter int MAX_LONG        = 4,
    parameter int STALL_CNT_WIDTH = 32,
    parameter int FWD_EN          = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RF_ADDR_WIDTH-1:0]   rs1_id,
    input  logic [RF_ADDR_WIDTH-1:0]   rs2_id,
    input  logic                       rs1_used_id,
    input  logic                       rs2_used_id,
    input  logic [RF_ADDR_WIDTH-1:0]   rd_id,
    input  logic                       reg_write_id,
    input  logic                       long_id,
    input  logic                       stall_ext,
    input  logic [RF_ADDR_WIDTH-1:0]   rs1_id2ex_ff,
    input  logic [RF_ADDR_WIDTH-1:0]   rs2_id2ex_ff,
    input  logic [RF_ADDR_WIDTH-1:0]   rd_id2ex_ff,
    input  logic                       reg_write_id2ex_ff,
    input  logic                       mem_read_id2ex_ff,
    input  logic [RF_ADDR_WIDTH-1:0]   rd_ex2mem_ff,
    input  logic                       reg_write_ex2mem_ff,
    input  logic [RF_ADDR_WIDTH-1:0]   rd_mem2wb_ff,
    input  logic                       reg_write_mem2wb_ff,
    input  logic                       long_done,
    input  logic [RF_ADDR_WIDTH-1:0]   long_done_rd,
    output logic [1:0]                 fwd_a,
    output logic [1:0]                 fwd_b,
    output logic                       stall_id,
    output logic                       bubble_ex,
    output logic                       long_busy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    localparam int NUM_REGS = 1 << RF_ADDR_WIDTH;
    localparam int CNT_W    = $clog2(MAX_LONG + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LONG);
    localparam bit FWD = (FWD_EN != 0);
    localparam logic [RF_ADDR_WIDTH-1:0] X0 = '0;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [CNT_W-1:0]    count;
    logic                waw_hit;
    logic                cap_hit;
    logic                accept;

    // A completing long op releases its register this cycle; the RF write-through supplies the value.
    function automatic logic src_hit(input logic [RF_ADDR_WIDTH-1:0] r, input logic used);
        logic pend_hit;
        logic load_use;
        logic no_fwd;
        pend_hit = pending[r] && !(long_done && (long_done_rd == r));
        load_use = FWD && mem_read_id2ex_ff && reg_write_id2ex_ff && (rd_id2ex_ff == r);
        no_fwd   = !FWD && ((reg_write_id2ex_ff  && (rd_id2ex_ff  == r)) ||
                            (reg_write_ex2mem_ff && (rd_ex2mem_ff == r)) ||
                            (reg_write_mem2wb_ff && (rd_mem2wb_ff == r)));
        return used && (r != X0) && (pend_hit || load_use || no_fwd);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RF_ADDR_WIDTH-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (FWD) begin
            if (reg_write_ex2mem_ff && (rd_ex2mem_ff != X0) && (rd_ex2mem_ff == src))
                sel = 2'b10;
            else if (reg_write_mem2wb_ff && (rd_mem2wb_ff != X0) && (rd_mem2wb_ff == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(rs1_id2ex_ff);
    assign fwd_b = fwd_sel(rs2_id2ex_ff);

    assign waw_hit   = reg_write_id && (rd_id != X0) && pending[rd_id];
    assign cap_hit   = long_id && (count == MAX_CNT);
    assign stall_id  = src_hit(rs1_id, rs1_used_id) | src_hit(rs2_id, rs2_used_id) | waw_hit | cap_hit;
    assign bubble_ex = stall_id & ~stall_ext;
    assign accept    = long_id && !stall_id && !stall_ext;
    assign long_busy = (count == MAX_CNT);

    // Clear before set, so an issue and completion on the same register leaves it pending.
    always_comb begin
        pending_next = pending;
        if (long_done)
            pending_next[long_done_rd] = 1'b0;
        if (accept && reg_write_id && (rd_id != X0))
            pending_next[rd_id] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            pending <= pending_next;
            case ({accept, long_done})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   if (count != '0) count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (stall_id && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench: a forwarding DUT (MAX_LONG=2, 3-bit stall counter) and an interlock-only DUT
// share stimulus; expected responses are queued and checked by an independent monitor.
module tb_riscv_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       rs1_used_id, rs2_used_id, reg_write_id, long_id, stall_ext;
    logic [4:0] rs1_id2ex_ff, rs2_id2ex_ff, rd_id2ex_ff, rd_ex2mem_ff, rd_mem2wb_ff, long_done_rd;
    logic       reg_write_id2ex_ff, mem_read_id2ex_ff, reg_write_ex2mem_ff, reg_write_mem2wb_ff;
    logic       long_done;

    logic [1:0]  fwd_a, fwd_b, nf_fwd_a, nf_fwd_b;
    logic        stall_id, bubble_ex, long_busy, nf_stall_id, nf_bubble_ex, nf_long_busy;
    logic [2:0]  stall_cnt;
    logic [31:0] nf_stall_cnt;

    typedef struct packed {
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       stall;
        logic       bubble;
        logic       busy;
        logic [2:0] cnt;
        logic       chk_nf;
        logic       nf_stall;
        logic [1:0] nf_fwd_a;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [2:0] exp_cnt = '0;

    always #5 clk = ~clk;

    riscv_hazard_scoreboard #(.RF_ADDR_WIDTH(5), .MAX_LONG(2), .STALL_CNT_WIDTH(3), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .long_id(long_id), .stall_ext(stall_ext),
        .rs1_id2ex_ff(rs1_id2ex_ff), .rs2_id2ex_ff(rs2_id2ex_ff), .rd_id2ex_ff(rd_id2ex_ff),
        .reg_write_id2ex_ff(reg_write_id2ex_ff), .mem_read_id2ex_ff(mem_read_id2ex_ff),
        .rd_ex2mem_ff(rd_ex2mem_ff), .reg_write_ex2mem_ff(reg_write_ex2mem_ff),
        .rd_mem2wb_ff(rd_mem2wb_ff), .reg_write_mem2wb_ff(reg_write_mem2wb_ff),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .long_busy(long_busy), .stall_cnt(stall_cnt)
    );

    riscv_hazard_scoreboard #(.RF_ADDR_WIDTH(5), .MAX_LONG(2), .STALL_CNT_WIDTH(32), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .long_id(long_id), .stall_ext(stall_ext),
        .rs1_id2ex_ff(rs1_id2ex_ff), .rs2_id2ex_ff(rs2_id2ex_ff), .rd_id2ex_ff(rd_id2ex_ff),
        .reg_write_id2ex_ff(reg_write_id2ex_ff), .mem_read_id2ex_ff(mem_read_id2ex_ff),
        .rd_ex2mem_ff(rd_ex2mem_ff), .reg_write_ex2mem_ff(reg_write_ex2mem_ff),
        .rd_mem2wb_ff(rd_mem2wb_ff), .reg_write_mem2wb_ff(reg_write_mem2wb_ff),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .stall_id(nf_stall_id), .bubble_ex(nf_bubble_ex),
        .long_busy(nf_long_busy), .stall_cnt(nf_stall_cnt)
    );

    task automatic idleInputs();
        rs1_id = '0; rs2_id = '0; rd_id = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; reg_write_id = 1'b0; long_id = 1'b0; stall_ext = 1'b0;
        rs1_id2ex_ff = '0; rs2_id2ex_ff = '0; rd_id2ex_ff = '0; rd_ex2mem_ff = '0; rd_mem2wb_ff = '0;
        reg_write_id2ex_ff = 1'b0; mem_read_id2ex_ff = 1'b0;
        reg_write_ex2mem_ff = 1'b0; reg_write_mem2wb_ff = 1'b0;
        long_done = 1'b0; long_done_rd = '0;
    endtask

    // Queue the expectation for the cycle whose inputs are already driven, then advance one clock.
    task automatic applyStimulus(input string name, input logic [1:0] efa, input logic [1:0] efb,
                                 input logic estall, input logic ebusy,
                                 input logic chk_nf, input logic enf_stall, input logic [1:0] enf_fa);
        exp_t e;
        e.fwd_a    = efa;
        e.fwd_b    = efb;
        e.stall    = estall;
        e.bubble   = estall & ~stall_ext;
        e.busy     = ebusy;
        e.cnt      = exp_cnt;
        e.chk_nf   = chk_nf;
        e.nf_stall = enf_stall;
        e.nf_fwd_a = enf_fa;
        exp_q.push_back(e);
        name_q.push_back(name);
        if (estall && exp_cnt != 3'd7)
            exp_cnt = exp_cnt + 3'd1;
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic checkOutput(input string name, input string field, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s.%s actual=%0d expected=%0d", name, field, actual, expected);
        end
    endtask

    exp_t  mon_e;
    string mon_n;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checkOutput(mon_n, "fwd_a", int'(fwd_a), int'(mon_e.fwd_a));
            checkOutput(mon_n, "fwd_b", int'(fwd_b), int'(mon_e.fwd_b));
            checkOutput(mon_n, "stall_id", int'(stall_id), int'(mon_e.stall));
            checkOutput(mon_n, "bubble_ex", int'(bubble_ex), int'(mon_e.bubble));
            checkOutput(mon_n, "long_busy", int'(long_busy), int'(mon_e.busy));
            checkOutput(mon_n, "stall_cnt", int'(stall_cnt), int'(mon_e.cnt));
            if (mon_e.chk_nf) begin
                checkOutput(mon_n, "nf_stall_id", int'(nf_stall_id), int'(mon_e.nf_stall));
                checkOutput(mon_n, "nf_fwd_a", int'(nf_fwd_a), int'(mon_e.nf_fwd_a));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idleInputs();
        @(posedge clk); #1;
        doReset();

        // Forwarding priority and interlock-only mode
        rd_ex2mem_ff = 5; reg_write_ex2mem_ff = 1; rd_mem2wb_ff = 5; reg_write_mem2wb_ff = 1; rs1_id2ex_ff = 5;
        applyStimulus("fwd_ex_prio", 2'b10, 2'b00, 0, 0, 1, 0, 2'b00);
        rd_ex2mem_ff = 5; rd_mem2wb_ff = 5; reg_write_mem2wb_ff = 1; rs1_id2ex_ff = 5; rs2_id2ex_ff = 5;
        applyStimulus("fwd_wb", 2'b01, 2'b01, 0, 0, 1, 0, 2'b00);
        reg_write_ex2mem_ff = 1; reg_write_mem2wb_ff = 1;
        applyStimulus("fwd_rd0", 2'b00, 2'b00, 0, 0, 1, 0, 2'b00);
        rd_ex2mem_ff = 6; reg_write_ex2mem_ff = 1; rd_mem2wb_ff = 7; reg_write_mem2wb_ff = 1;
        rs1_id2ex_ff = 7; rs2_id2ex_ff = 6;
        applyStimulus("fwd_mixed", 2'b01, 2'b10, 0, 0, 1, 0, 2'b00);
        rd_ex2mem_ff = 5; reg_write_ex2mem_ff = 1; rs1_id2ex_ff = 5; rs1_id = 5; rs1_used_id = 1;
        applyStimulus("nofwd_ex2mem", 2'b10, 2'b00, 0, 0, 1, 1, 2'b00);

        // Load-use
        mem_read_id2ex_ff = 1; reg_write_id2ex_ff = 1; rd_id2ex_ff = 7; rs2_id = 7; rs2_used_id = 1;
        applyStimulus("load_use", 2'b00, 2'b00, 1, 0, 1, 1, 2'b00);
        rd_ex2mem_ff = 7; reg_write_ex2mem_ff = 1; rs2_id = 7; rs2_used_id = 1;
        applyStimulus("load_use_after", 2'b00, 2'b00, 0, 0, 1, 1, 2'b00);
        mem_read_id2ex_ff = 1; reg_write_id2ex_ff = 1; rd_id2ex_ff = 7; rs2_id = 7;
        applyStimulus("load_use_unused", 2'b00, 2'b00, 0, 0, 1, 0, 2'b00);
        mem_read_id2ex_ff = 1; reg_write_id2ex_ff = 1; rd_id2ex_ff = 7; rs2_id = 7; rs2_used_id = 1; stall_ext = 1;
        applyStimulus("load_use_ext", 2'b00, 2'b00, 1, 0, 1, 1, 2'b00);
        mem_read_id2ex_ff = 1; reg_write_id2ex_ff = 1; rs1_used_id = 1;
        applyStimulus("load_x0", 2'b00, 2'b00, 0, 0, 1, 0, 2'b00);

        // Scoreboard RAW with completion bypass
        long_id = 1; rd_id = 9; reg_write_id = 1;
        applyStimulus("issue_x9", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        rs1_id = 9; rs1_used_id = 1;
        applyStimulus("raw_x9", 2'b00, 2'b00, 1, 0, 0, 0, 2'b00);
        rs1_id = 9; rs1_used_id = 1;
        applyStimulus("raw_x9_hold", 2'b00, 2'b00, 1, 0, 0, 0, 2'b00);
        rs1_id = 9; rs1_used_id = 1; long_done = 1; long_done_rd = 9;
        applyStimulus("done_x9_bypass", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        rs1_id = 9; rs1_used_id = 1;
        applyStimulus("raw_x9_clear", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);

        // Capacity, same-cycle issue/done, WAW
        long_id = 1; rd_id = 3; reg_write_id = 1;
        applyStimulus("issue_x3", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_id = 1; rd_id = 4; reg_write_id = 1;
        applyStimulus("issue_x4", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        applyStimulus("busy_full", 2'b00, 2'b00, 0, 1, 0, 0, 2'b00);
        long_id = 1; rd_id = 10; reg_write_id = 1;
        applyStimulus("cap_stall", 2'b00, 2'b00, 1, 1, 0, 0, 2'b00);
        long_id = 1; rd_id = 10; reg_write_id = 1; long_done = 1; long_done_rd = 3;
        applyStimulus("cap_stall_done", 2'b00, 2'b00, 1, 1, 0, 0, 2'b00);
        long_id = 1; rd_id = 5; reg_write_id = 1; long_done = 1; long_done_rd = 4;
        applyStimulus("issue_done_same", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        applyStimulus("count_kept", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_id = 1; rd_id = 6; reg_write_id = 1; long_done = 1; long_done_rd = 6;
        applyStimulus("same_rd_race", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        rd_id = 6; reg_write_id = 1;
        applyStimulus("waw_x6", 2'b00, 2'b00, 1, 0, 0, 0, 2'b00);
        rd_id = 5; reg_write_id = 1;
        applyStimulus("waw_x5", 2'b00, 2'b00, 1, 0, 0, 0, 2'b00);
        rs2_id = 6; rs2_used_id = 1;
        applyStimulus("raw_x6_sat", 2'b00, 2'b00, 1, 0, 0, 0, 2'b00);
        rd_id = 3; reg_write_id = 1;
        applyStimulus("waw_x3_clear", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_id = 1; rd_id = 7; reg_write_id = 1;
        applyStimulus("issue_x7", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        applyStimulus("busy_two", 2'b00, 2'b00, 0, 1, 0, 0, 2'b00);

        // Reset with two outstanding, then a spurious completion
        doReset();
        rs1_id = 6; rs1_used_id = 1;
        applyStimulus("post_reset", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_done = 1; long_done_rd = 6;
        applyStimulus("spurious_done", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_id = 1; rd_id = 6; reg_write_id = 1;
        applyStimulus("issue_x6", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        long_id = 1; rd_id = 11; reg_write_id = 1;
        applyStimulus("issue_x11", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        applyStimulus("busy_again", 2'b00, 2'b00, 0, 1, 0, 0, 2'b00);

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
